modular_exponentiator: RTL and testbench



---
 rtl/crypto_pkg.sv | 7 +
 rtl/modular_multiplier.sv | 55 +++++
 rtl/modular_exponentiator.sv | 120 ++++++++++++
 tb/tb_modular_exponentiator.sv | 108 ++++++++++
 4 files changed

// File: rtl/crypto_pkg.sv
// crypto_pkg: shared width default and exponentiator state encoding.
package crypto_pkg;
  localparam int CRYPTO_N = 8;
  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_NEXT, S_ISSUE_MUL, S_WAIT_MUL, S_ISSUE_SQR, S_WAIT_SQR, S_FINISH
  } modexp_state_t;
endpackage

// File: rtl/modular_multiplier.sv
// modular_multiplier: P = X*Y mod M by MSB-first interleaved double-and-add, one Y bit per cycle.
module modular_multiplier import crypto_pkg::*; #(
  parameter int n = CRYPTO_N
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         start,
  input  logic [n-1:0] X,
  input  logic [n-1:0] Y,
  input  logic [n-1:0] M,
  output logic [n-1:0] P,
  output logic         done
);
  localparam int IW = $clog2(n);
  logic [n-1:0] acc_q, acc_d;
  logic [IW-1:0] i_q, i_d;
  logic run_q, run_d, done_q, done_d;
  logic [n:0] mw, dbl, r1, s, r2;
  always_comb begin
    mw = {1'b0, M};
    dbl = {acc_q, 1'b0};
    r1 = dbl >= mw ? dbl - mw : dbl;
    s = r1 + (Y[i_q] ? {1'b0, X} : '0);
    r2 = s >= mw ? s - mw : s;
    acc_d = acc_q;
    i_d = i_q;
    run_d = run_q;
    done_d = 1'b0;
    if (run_q) begin
      acc_d = n'(r2);
      i_d = i_q - IW'(1);
      run_d = i_q != '0;
      done_d = i_q == '0;
    end else if (start) begin
      acc_d = '0;
      i_d = IW'(n - 1);
      run_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      acc_q <= '0;
      i_q <= '0;
      run_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      i_q <= i_d;
      run_q <= run_d;
      done_q <= done_d;
    end
  end
  assign P = acc_q;
  assign done = done_q;
endmodule

// File: rtl/modular_exponentiator.sv
// modular_exponentiator: R = B^E mod M, right-to-left square-and-multiply over modular_multiplier.
// Define MODEXP_EARLY_EXIT_EN to stop once the remaining exponent bits are all zero.
module modular_exponentiator import crypto_pkg::*; #(
  parameter int n = CRYPTO_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] B,
  input  logic [n-1:0] E,
  input  logic [n-1:0] M,
  output logic [n-1:0] R,
  output logic         done,
  output logic         busy,
  output logic         err
);
  localparam int CW = $clog2(n + 1);
  modexp_state_t state_q, state_d;
  logic [n-1:0] a_q, a_d, r_q, r_d, e_q, e_d, m_q, m_d, res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic done_q, done_d, busy_q, busy_d, err_q, err_d, last;
  logic mul_start, mul_done;
  logic [n-1:0] mul_x, mul_p;
  assign mul_start = state_q == S_ISSUE_MUL || state_q == S_ISSUE_SQR;
  assign mul_x = (state_q == S_ISSUE_SQR || state_q == S_WAIT_SQR) ? a_q : r_q;
`ifdef MODEXP_EARLY_EXIT_EN
  assign last = cnt_q == CW'(n) || e_q == '0;
`else
  assign last = cnt_q == CW'(n);
`endif
  modular_multiplier #(.n(n)) u_mul (
    .clk(clk), .n_reset(~reset), .start(mul_start),
    .X(mul_x), .Y(a_q), .M(m_q), .P(mul_p), .done(mul_done)
  );
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    r_d = r_q;
    e_d = e_q;
    m_d = m_q;
    cnt_d = cnt_q;
    res_d = res_q;
    done_d = 1'b0;
    busy_d = busy_q;
    err_d = err_q;
    case (state_q)
      S_IDLE: begin
        busy_d = start && !busy_q;
        if (start && !busy_q) begin
          a_d = B;
          e_d = E;
          m_d = M;
          r_d = n'(1);
          cnt_d = '0;
          err_d = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (m_q < n'(2) || a_q >= m_q) begin
          err_d = 1'b1;
          r_d = '0;
          state_d = S_FINISH;
        end else state_d = S_NEXT;
      end
      S_NEXT: state_d = last ? S_FINISH : e_q[0] ? S_ISSUE_MUL : S_ISSUE_SQR;
      S_ISSUE_MUL: state_d = S_WAIT_MUL;
      S_WAIT_MUL: begin
        if (mul_done) begin
          r_d = mul_p;
          state_d = S_ISSUE_SQR;
        end
      end
      S_ISSUE_SQR: state_d = S_WAIT_SQR;
      S_WAIT_SQR: begin
        if (mul_done) begin
          a_d = mul_p;
          e_d = e_q >> 1;
          cnt_d = cnt_q + CW'(1);
          state_d = S_NEXT;
        end
      end
      S_FINISH: begin
        res_d = r_q;
        done_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q <= '0;
      r_q <= '0;
      e_q <= '0;
      m_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      r_q <= r_d;
      e_q <= e_d;
      m_q <= m_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
      done_q <= done_d;
      busy_q <= busy_d;
      err_q <= err_d;
    end
  end
  assign R = res_q;
  assign done = done_q;
  assign busy = busy_q;
  assign err = err_q;
endmodule

// File: tb/tb_modular_exponentiator.sv
// tb_modular_exponentiator: directed and random checks of modular_exponentiator against a plain-arithmetic model.
module tb_modular_exponentiator;
  localparam int N = 8;
  logic clk = 1'b0;
  logic reset, start, done, busy, err;
  logic [N-1:0] B, E, M, R;
  int n_asserts = 0, n_fails = 0;
  int lat, lat1, lat128;
  bit quiet;

  modular_exponentiator #(.n(N)) dut (
    .clk(clk), .reset(reset), .start(start), .B(B), .E(E), .M(M),
    .R(R), .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input int b, input int e, input int m);
    longint r = 1;
    if (m < 2 || b >= m) return 0;
    for (int i = 0; i < e; i++) r = (r * b) % m;
    return 32'(r % m);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run(input int b, input int e, input int m, input bit inj, output int cyc);
    bit busy_ok = 1'b1;
    cyc = 0;
    B = N'(b); E = N'(e); M = N'(m); start = 1'b1;
    do begin
      @(posedge clk); #1;
      cyc++;
      start = inj && cyc == 4;
      if (start) begin B = 2; E = 255; M = 11; end
      if (!busy) busy_ok = 1'b0;
    end while (!done && cyc < 1000);
    start = 1'b0;
    check("done_seen", {31'd0, done}, 1);
    check("busy_through_op", {31'd0, busy_ok}, 1);
    check("result", {24'd0, R}, model(b, e, m));
    check("err_flag", {31'd0, err}, (m < 2 || b >= m) ? 1 : 0);
    @(posedge clk); #1;
    check("done_single", {31'd0, done}, 0);
    check("busy_fall", {31'd0, busy}, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; B = '0; E = '0; M = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_R", {24'd0, R}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_err", {31'd0, err}, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    run(7, 2, 10, 0, lat);
    run(3, 5, 7, 0, lat);
    run(2, 255, 11, 0, lat);
    run(5, 0, 13, 0, lat);
    run(0, 3, 13, 0, lat);
    run(0, 1, 1, 0, lat);
    check("illegal_m1_latency", lat, 3);
    run(12, 3, 10, 0, lat);
    check("illegal_b_ge_m_latency", lat, 3);
    run(3, 5, 7, 0, lat);
    run(2, 1, 11, 0, lat1);
    run(2, 128, 11, 0, lat128);
`ifdef MODEXP_EARLY_EXIT_EN
    check("early_exit_faster", {31'd0, lat1 < lat128}, 1);
`else
    check("fixed_square_count", lat1, lat128);
`endif
    B = 3; E = 255; M = 11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_done", {31'd0, done}, 0);
    reset = 1'b0;
    run(7, 2, 10, 0, lat);
    run(3, 5, 7, 1, lat);
    quiet = 1'b1;
    repeat (300) begin
      @(posedge clk); #1;
      if (done || busy) quiet = 1'b0;
    end
    check("ignored_second_start", {31'd0, quiet}, 1);
    repeat (20) begin
      int m = $urandom_range(2, 255);
      int b = $urandom_range(0, m - 1);
      int e = $urandom_range(0, 255);
      run(b, e, m, 0, lat);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end
endmodule
